ps2_key_sequencer: RTL and testbench

//  Sequences the decoded byte stream from the PS/2 receiver into key events.

---
 rtl/ps2_key_sequencer_if.sv | 22 ++
 rtl/ps2_key_sequencer.sv | 121 ++++++++++++
 tb/tb_ps2_key_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_sequencer_if.sv
// Byte-in / key-event-out handshake bundle for the PS/2 key sequencer.
// The slave side is the sequencer; the master side feeds bytes and takes events.
interface ps2_key_sequencer_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_release;
   logic       ev_ext;

   modport master (
      output rx_valid, rx_data, ev_ready,
      input  rx_ready, ev_valid, ev_code, ev_release, ev_ext
   );

   modport slave (
      input  rx_valid, rx_data, ev_ready,
      output rx_ready, ev_valid, ev_code, ev_release, ev_ext
   );
endinterface

// File: rtl/ps2_key_sequencer.sv
// Turns the PS/2 scancode byte stream into make/break key events.
// Define PS2_EXT_KEY_EN to build E0 (extended key) prefix handling.
module ps2_key_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   ps2_key_sequencer_if.slave bus,
   output logic [7:0]       cur_code,
   output logic             key_down,
   output logic [CNT_W-1:0] press_cnt,
   output logic             seg_en,
   output logic             err
);

   localparam logic [7:0] B_EXT = 8'hE0;
   localparam logic [7:0] B_BRK = 8'hF0;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, EXT, BRK} state_t;

   state_t     state;
   logic       ext_q;
   logic       cur_ext;
   logic       accept;
   logic       is_repeat;
   logic [7:0] b;

   assign b           = bus.rx_data;
   assign bus.rx_ready = !bus.ev_valid;
   assign accept      = bus.rx_valid && !bus.ev_valid;
   assign seg_en      = key_down;

   // Held key re-sent by typematic repeat; ext flag must match too.
   assign is_repeat = key_down && (b == cur_code) && (cur_ext == ext_q);

   // Prefix FSM, event register and key tracking in one clocked block.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state          <= IDLE;
         ext_q          <= 1'b0;
         cur_ext        <= 1'b0;
         cur_code       <= 8'h00;
         key_down       <= 1'b0;
         press_cnt      <= '0;
         err            <= 1'b0;
         bus.ev_valid   <= 1'b0;
         bus.ev_code    <= 8'h00;
         bus.ev_release <= 1'b0;
         bus.ev_ext     <= 1'b0;
      end else begin
         err <= 1'b0;
         if (bus.ev_valid && bus.ev_ready)
            bus.ev_valid <= 1'b0;
         if (accept) begin
            unique case (state)
               IDLE: begin
                  if (b == B_EXT) begin
`ifdef PS2_EXT_KEY_EN
                     state <= EXT;
                     ext_q <= 1'b1;
`endif
                  end else if (b == B_BRK) begin
                     state <= BRK;
                  end else if (!is_repeat) begin
                     bus.ev_valid   <= 1'b1;
                     bus.ev_code    <= b;
                     bus.ev_release <= 1'b0;
                     bus.ev_ext     <= 1'b0;
                     cur_code       <= b;
                     cur_ext        <= 1'b0;
                     key_down       <= 1'b1;
                     press_cnt      <= press_cnt + CNT_ONE;
                  end
               end
`ifdef PS2_EXT_KEY_EN
               EXT: begin
                  if (b == B_BRK) begin
                     state <= BRK;
                  end else if (b == B_EXT) begin
                     err <= 1'b1;
                  end else begin
                     state <= IDLE;
                     ext_q <= 1'b0;
                     if (!is_repeat) begin
                        bus.ev_valid   <= 1'b1;
                        bus.ev_code    <= b;
                        bus.ev_release <= 1'b0;
                        bus.ev_ext     <= 1'b1;
                        cur_code       <= b;
                        cur_ext        <= 1'b1;
                        key_down       <= 1'b1;
                        press_cnt      <= press_cnt + CNT_ONE;
                     end
                  end
               end
`endif
               BRK: begin
                  if (b == B_EXT || b == B_BRK) begin
                     err <= 1'b1;
                  end else begin
                     state          <= IDLE;
                     ext_q          <= 1'b0;
                     bus.ev_valid   <= 1'b1;
                     bus.ev_code    <= b;
                     bus.ev_release <= 1'b1;
                     bus.ev_ext     <= ext_q;
                     if (b == cur_code)
                        key_down <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
                  ext_q <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed self-checking bench for ps2_key_sequencer.
// Expected ext bits follow PS2_EXT_KEY_EN as built.
module tb_ps2_key_sequencer;

   logic       clk;
   logic       resetn;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       ev_ready;

   logic [7:0] cur_code, cur_code2;
   logic       key_down, key_down2;
   logic [7:0] press_cnt;
   logic [1:0] press_cnt2;
   logic       seg_en, seg_en2;
   logic       err, err2;

   int n_checks;
   int n_fail;
   int err_cnt;
   logic [9:0] evq[$];

`ifdef PS2_EXT_KEY_EN
   localparam logic EXT_ON = 1'b1;
`else
   localparam logic EXT_ON = 1'b0;
`endif

   ps2_key_sequencer_if bus ();
   ps2_key_sequencer_if bus2 ();

   assign bus.rx_valid  = rx_valid;
   assign bus.rx_data   = rx_data;
   assign bus.ev_ready  = ev_ready;
   assign bus2.rx_valid = rx_valid;
   assign bus2.rx_data  = rx_data;
   assign bus2.ev_ready = ev_ready;

   ps2_key_sequencer #(.CNT_W(8)) u_dut (
      .clk(clk), .resetn(resetn), .bus(bus),
      .cur_code(cur_code), .key_down(key_down),
      .press_cnt(press_cnt), .seg_en(seg_en), .err(err)
   );

   ps2_key_sequencer #(.CNT_W(2)) u_dut2 (
      .clk(clk), .resetn(resetn), .bus(bus2),
      .cur_code(cur_code2), .key_down(key_down2),
      .press_cnt(press_cnt2), .seg_en(seg_en2), .err(err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record retired events and err pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (resetn && bus.ev_valid && ev_ready)
         evq.push_back({bus.ev_ext, bus.ev_release, bus.ev_code});
      if (resetn && err)
         err_cnt++;
   end

   task automatic do_reset();
      resetn   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      ev_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      evq.delete();
      err_cnt = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.rx_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      n_checks++;
      if (!bus.rx_ready) begin
         n_fail++;
         $display("FAIL accept_timeout byte=%h rx_ready=%b want 1", b, bus.rx_ready);
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 8'h1C;
      ev_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.ev_valid, bus.ev_code, bus.ev_release, bus.ev_ext} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_ev got=%b want 0",
                  {bus.ev_valid, bus.ev_code, bus.ev_release, bus.ev_ext});
      end
      n_checks++;
      if ({cur_code, key_down, press_cnt, seg_en, err} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_state got=%h want 0",
                  {cur_code, key_down, press_cnt, seg_en, err});
      end
      n_checks++;
      if (bus.rx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_rx_ready got=%b want 1", bus.rx_ready);
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_reset_mid_event();
      do_reset();
      ev_ready = 1'b0;
      send_byte(8'h1C);
      @(negedge clk);
      n_checks++;
      if (bus.ev_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pending got=%b want 1", bus.ev_valid);
      end
      resetn = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.ev_valid, press_cnt, key_down} !== 10'd0) begin
         n_fail++;
         $display("FAIL mid_dropped got=%h want 0",
                  {bus.ev_valid, press_cnt, key_down});
      end
      ev_ready = 1'b1;
   endtask

   task automatic test_make_break();
      do_reset();
      send_byte(8'h1C);
      idle(3);
      n_checks++;
      if ({press_cnt, key_down, seg_en, cur_code} !== {8'd1, 1'b1, 1'b1, 8'h1C}) begin
         n_fail++;
         $display("FAIL make_state cnt=%0d kd=%b seg=%b code=%h want 1 1 1 1c",
                  press_cnt, key_down, seg_en, cur_code);
      end
      send_byte(8'hF0);
      send_byte(8'h1C);
      idle(3);
      n_checks++;
      if (evq.size() != 2) begin
         n_fail++;
         $display("FAIL mb_count got=%0d want 2", evq.size());
      end else begin
         n_checks++;
         if (evq[0] !== {1'b0, 1'b0, 8'h1C} || evq[1] !== {1'b0, 1'b1, 8'h1C}) begin
            n_fail++;
            $display("FAIL mb_events got=%h,%h want 01c,11c", evq[0], evq[1]);
         end
      end
      n_checks++;
      if ({key_down, seg_en, press_cnt} !== {1'b0, 1'b0, 8'd1}) begin
         n_fail++;
         $display("FAIL break_state kd=%b seg=%b cnt=%0d want 0 0 1",
                  key_down, seg_en, press_cnt);
      end
   endtask

   task automatic test_typematic();
      do_reset();
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h1C);
      idle(3);
      n_checks++;
      if (evq.size() != 2 || press_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL typematic events=%0d cnt=%0d want 2 1", evq.size(), press_cnt);
      end else begin
         n_checks++;
         if (evq[1] !== {1'b0, 1'b1, 8'h1C}) begin
            n_fail++;
            $display("FAIL typematic_rel got=%h want 11c", evq[1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      do_reset();
      ev_ready = 1'b0;
      send_byte(8'h1C);
      rx_data  = 8'h32;
      rx_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.ev_valid !== 1'b1 || bus.ev_code !== 8'h1C || bus.rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold cyc=%0d v=%b code=%h rdy=%b want 1 1c 0",
                     i, bus.ev_valid, bus.ev_code, bus.rx_ready);
         end
      end
      @(posedge clk);
      #1 ev_ready = 1'b1;
      send_byte(8'h32);
      idle(3);
      n_checks++;
      if (evq.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_count got=%0d want 2", evq.size());
      end else begin
         n_checks++;
         if (evq[0] !== {2'b00, 8'h1C} || evq[1] !== {2'b00, 8'h32}) begin
            n_fail++;
            $display("FAIL b2b_events got=%h,%h want 01c,032", evq[0], evq[1]);
         end
      end
      n_checks++;
      if (press_cnt !== 8'd2 || cur_code !== 8'h32) begin
         n_fail++;
         $display("FAIL b2b_state cnt=%0d code=%h want 2 32", press_cnt, cur_code);
      end
   endtask

   task automatic test_ext();
      do_reset();
      send_byte(8'hE0);
      send_byte(8'h75);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      idle(3);
      n_checks++;
      if (evq.size() != 2) begin
         n_fail++;
         $display("FAIL ext_count got=%0d want 2", evq.size());
      end else begin
         n_checks++;
         if (evq[0] !== {EXT_ON, 1'b0, 8'h75} || evq[1] !== {EXT_ON, 1'b1, 8'h75}) begin
            n_fail++;
            $display("FAIL ext_events got=%h,%h want ext=%b", evq[0], evq[1], EXT_ON);
         end
      end
      n_checks++;
      if (key_down !== 1'b0 || err_cnt != 0) begin
         n_fail++;
         $display("FAIL ext_state kd=%b errs=%0d want 0 0", key_down, err_cnt);
      end
   endtask

   task automatic test_ext_distinct();
      do_reset();
      send_byte(8'h75);
      send_byte(8'hE0);
      send_byte(8'h75);
      send_byte(8'hE0);
      send_byte(8'hE0);
      idle(3);
      n_checks++;
      if (press_cnt !== (EXT_ON ? 8'd2 : 8'd1)) begin
         n_fail++;
         $display("FAIL ext_distinct cnt=%0d want %0d", press_cnt, EXT_ON ? 2 : 1);
      end
      n_checks++;
      if (err_cnt != (EXT_ON ? 1 : 0)) begin
         n_fail++;
         $display("FAIL ext_double_e0 errs=%0d want %0d", err_cnt, EXT_ON ? 1 : 0);
      end
   endtask

   task automatic test_err();
      do_reset();
      send_byte(8'hF0);
      send_byte(8'hF0);
      send_byte(8'h1C);
      idle(3);
      n_checks++;
      if (err_cnt != 1) begin
         n_fail++;
         $display("FAIL err_pulses got=%0d want 1", err_cnt);
      end
      n_checks++;
      if (evq.size() != 1) begin
         n_fail++;
         $display("FAIL err_count got=%0d want 1", evq.size());
      end else begin
         n_checks++;
         if (evq[0] !== {1'b0, 1'b1, 8'h1C}) begin
            n_fail++;
            $display("FAIL err_release got=%h want 11c", evq[0]);
         end
      end
      n_checks++;
      if (press_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL err_cnt_state got=%0d want 0", press_cnt);
      end
   endtask

   task automatic test_cnt_wrap();
      do_reset();
      send_byte(8'h11);
      send_byte(8'h12);
      send_byte(8'h13);
      send_byte(8'h14);
      send_byte(8'h15);
      idle(3);
      n_checks++;
      if (press_cnt2 !== 2'd1) begin
         n_fail++;
         $display("FAIL cnt_wrap got=%0d want 1", press_cnt2);
      end
      n_checks++;
      if (press_cnt !== 8'd5 || cur_code2 !== 8'h15) begin
         n_fail++;
         $display("FAIL cnt_wide cnt=%0d code2=%h want 5 15", press_cnt, cur_code2);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      err_cnt  = 0;
      resetn   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      ev_ready = 1'b1;
      test_reset();
      test_reset_mid_event();
      test_make_break();
      test_typematic();
      test_back_to_back();
      test_ext();
      test_ext_distinct();
      test_err();
      test_cnt_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
